// File: rtl/alu_sequencer_if.sv
// Handshake bundle between upstream parsers, the sequencer and the shared ALU.
// The sequencer takes the slave view; the environment driving it takes the master view.
interface alu_sequencer_if #(
    parameter int unsigned WIDTH = 16
);
    logic             i_opnd_ready;
    logic [WIDTH-1:0] i_opnd;
    logic             i_op_ready;
    logic [7:0]       i_op_code;
    logic             o_alu_start;
    logic [2:0]       o_alu_op;
    logic [WIDTH-1:0] o_alu_a;
    logic [WIDTH-1:0] o_alu_b;
    logic             i_alu_done;
    logic [WIDTH-1:0] i_alu_result;
    logic             i_alu_err;
    logic             o_busy;
    logic             o_ready;
    logic [WIDTH-1:0] o_result;
    logic [1:0]       o_error;

    modport slave (
        input  i_opnd_ready, i_opnd, i_op_ready, i_op_code,
        input  i_alu_done, i_alu_result, i_alu_err,
        output o_alu_start, o_alu_op, o_alu_a, o_alu_b,
        output o_busy, o_ready, o_result, o_error
    );

    modport master (
        output i_opnd_ready, i_opnd, i_op_ready, i_op_code,
        output i_alu_done, i_alu_result, i_alu_err,
        input  o_alu_start, o_alu_op, o_alu_a, o_alu_b,
        input  o_busy, o_ready, o_result, o_error
    );
endinterface

// File: rtl/alu_sequencer.sv
// Collects A / op / B strobes, runs one start/done transaction on the shared ALU and
// returns result or error code; a result can be chained as the next operand A.
module alu_sequencer #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic            i_clk,
    input  logic            reset,
    alu_sequencer_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] ERR_OK  = 2'd0;
    localparam logic [1:0] ERR_DIV = 2'd1;
    localparam logic [1:0] ERR_SEQ = 2'd2;
    localparam logic [1:0] ERR_TMO = 2'd3;

    typedef enum logic [2:0] {IDLE, GET_OP, GET_B, ISSUE, WAIT_ALU} state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [2:0]         op_q, op_d;
    logic               chain_q, chain_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               start_q, start_d;
    logic [2:0]         alu_op_q, alu_op_d;
    logic [WIDTH-1:0]   alu_a_q, alu_a_d;
    logic [WIDTH-1:0]   alu_b_q, alu_b_d;
    logic               busy_q, busy_d;
    logic               ready_q, ready_d;
    logic [WIDTH-1:0]   result_q, result_d;
    logic [1:0]         error_q, error_d;

    always_ff @(posedge i_clk) begin
        if (!reset) begin
            state_q  <= IDLE;
            a_q      <= '0;
            op_q     <= '0;
            chain_q  <= 1'b0;
            cnt_q    <= '0;
            start_q  <= 1'b0;
            alu_op_q <= '0;
            alu_a_q  <= '0;
            alu_b_q  <= '0;
            busy_q   <= 1'b0;
            ready_q  <= 1'b0;
            result_q <= '0;
            error_q  <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            op_q     <= op_d;
            chain_q  <= chain_d;
            cnt_q    <= cnt_d;
            start_q  <= start_d;
            alu_op_q <= alu_op_d;
            alu_a_q  <= alu_a_d;
            alu_b_q  <= alu_b_d;
            busy_q   <= busy_d;
            ready_q  <= ready_d;
            result_q <= result_d;
            error_q  <= error_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        op_d     = op_q;
        chain_d  = chain_q;
        cnt_d    = cnt_q;
        start_d  = 1'b0;
        alu_op_d = alu_op_q;
        alu_a_d  = alu_a_q;
        alu_b_d  = alu_b_q;
        ready_d  = 1'b0;
        result_d = result_q;
        error_d  = error_q;

        case (state_q)
            IDLE: begin
                if (bus.i_opnd_ready) begin
                    a_d     = bus.i_opnd;
                    state_d = GET_OP;
                end else if (bus.i_op_ready) begin
                    ready_d = 1'b1;
                    error_d = ERR_SEQ;
                    chain_d = 1'b0;
                end
            end
            GET_OP: begin
                // the op strobe is the expected one here, so it wins over a coincident operand
                if (bus.i_op_ready) begin
                    chain_d = 1'b0;
                    if (bus.i_op_code >= 8'd1 && bus.i_op_code <= 8'd4) begin
                        op_d    = 3'(bus.i_op_code);
                        state_d = GET_B;
                    end else begin
                        ready_d = 1'b1;
                        error_d = ERR_SEQ;
                        state_d = IDLE;
                    end
                end else if (bus.i_opnd_ready) begin
                    chain_d = 1'b0;
                    if (chain_q) begin
                        a_d = bus.i_opnd;
                    end else begin
                        ready_d = 1'b1;
                        error_d = ERR_SEQ;
                        state_d = IDLE;
                    end
                end
            end
            GET_B: begin
                if (bus.i_opnd_ready) begin
                    start_d  = 1'b1;
                    alu_a_d  = a_q;
                    alu_b_d  = bus.i_opnd;
                    alu_op_d = op_q;
                    state_d  = ISSUE;
                end else if (bus.i_op_ready) begin
                    ready_d = 1'b1;
                    error_d = ERR_SEQ;
                    chain_d = 1'b0;
                    state_d = IDLE;
                end
            end
            ISSUE: begin
                cnt_d   = '0;
                state_d = WAIT_ALU;
            end
            WAIT_ALU: begin
                if (bus.i_alu_done) begin
                    ready_d = 1'b1;
                    chain_d = 1'b1;
                    state_d = GET_OP;
                    if (bus.i_alu_err) begin
                        error_d = ERR_DIV;
                        a_d     = result_q;
                    end else begin
                        error_d  = ERR_OK;
                        result_d = bus.i_alu_result;
                        a_d      = bus.i_alu_result;
                    end
                end else if (cnt_q == CNT_W'(TIMEOUT - 2)) begin
                    // counter is about to reach TIMEOUT-1 without a done
                    ready_d = 1'b1;
                    error_d = ERR_TMO;
                    chain_d = 1'b0;
                    state_d = IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_d = (state_d == ISSUE) || (state_d == WAIT_ALU);

    assign bus.o_alu_start = start_q;
    assign bus.o_alu_op    = alu_op_q;
    assign bus.o_alu_a     = alu_a_q;
    assign bus.o_alu_b     = alu_b_q;
    assign bus.o_busy      = busy_q;
    assign bus.o_ready     = ready_q;
    assign bus.o_result    = result_q;
    assign bus.o_error     = error_q;
endmodule
